picodevice_irq_ctrl: RTL and testbench

- Interrupt front-end directly upstream of the picodevice IRQ interface.
- Synchronises raw peripheral interrupt lines into clk.
- Captures each line as level- or edge-triggered and drives the device-side irq[15:0].
- Tracks the device's eoi[15:0] handshake to retire each interrupt and return a one-cycle acknowledge pulse to the source peripheral.

---
 rtl/picodevice_irq_pkg.sv | 14 +
 rtl/picodevice_irq_line.sv | 127 ++++++++++++
 rtl/picodevice_irq_ctrl.sv | 53 +++++
 tb/tb_picodevice_irq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/picodevice_irq_pkg.sv
// Shared types and constants for the picodevice interrupt front-end.
// The line state encoding is fixed so the state flops can be read directly.
package picodevice_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'b00,
    IRQ_PEND = 2'b01,
    IRQ_SERV = 2'b10
  } irq_state_e;

  localparam int IRQ_LINES       = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/picodevice_irq_line.sv
// One interrupt line: synchroniser, trigger detect, IDLE/PEND/SERV state machine,
// and the rearm/lost tracking for edges that arrive while the line is in service.
module picodevice_irq_line
  import picodevice_irq_pkg::*;
#(
  parameter bit EDGE        = 1'b0,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_src_irq,
  input  logic i_enable,
  input  logic i_eoi_rise,
  input  logic i_eoi_fall,
  output logic o_irq,
  output logic o_src_ack,
  output logic o_lost
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  irq_state_e             r_state;
  irq_state_e             w_state_nxt;
  logic                   r_rearm;
  logic                   w_rearm_nxt;
  logic                   r_lost;
  logic                   w_lost_nxt;
  logic                   r_ack;
  logic                   w_ack_nxt;
  logic                   r_irq;
  logic                   w_s;
  logic                   w_trig;
  logic                   w_edge_trig;
  logic                   w_level_hold;

  assign w_s          = r_sync[SYNC_STAGES-1];
  assign w_trig       = EDGE ? (w_s & ~r_s_d) : w_s;
  assign w_edge_trig  = EDGE & w_trig;
  // A level line still asserted at retirement goes straight back to pending.
  assign w_level_hold = ~EDGE & w_s & i_enable;

  // Synchroniser chain and delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_src_irq};
      r_s_d  <= w_s;
    end
  end

  // Next-state, rearm/lost and acknowledge decode.
  always_comb begin
    w_state_nxt = r_state;
    w_rearm_nxt = r_rearm;
    w_lost_nxt  = r_lost;
    w_ack_nxt   = 1'b0;
    case (r_state)
      IRQ_IDLE: begin
        if (w_trig && i_enable) begin
          w_state_nxt = IRQ_PEND;
        end else begin
          w_state_nxt = IRQ_IDLE;
        end
      end
      IRQ_PEND: begin
        if (i_eoi_rise) begin
          w_state_nxt = IRQ_SERV;
        end else if (!i_enable) begin
          w_state_nxt = IRQ_IDLE;
        end else begin
          w_state_nxt = IRQ_PEND;
        end
      end
      IRQ_SERV: begin
        if (w_edge_trig) begin
          if (r_rearm) begin
            w_lost_nxt = 1'b1;
          end else begin
            w_rearm_nxt = 1'b1;
          end
        end else begin
          w_rearm_nxt = r_rearm;
        end
        // An edge coinciding with eoi fall still counts as a rearm.
        if (i_eoi_fall) begin
          w_ack_nxt   = 1'b1;
          w_rearm_nxt = 1'b0;
          if (r_rearm || w_edge_trig || w_level_hold) begin
            w_state_nxt = IRQ_PEND;
          end else begin
            w_state_nxt = IRQ_IDLE;
          end
        end else begin
          w_state_nxt = IRQ_SERV;
        end
      end
      default: begin
        w_state_nxt = IRQ_IDLE;
        w_rearm_nxt = 1'b0;
      end
    endcase
  end

  // State, flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IRQ_IDLE;
      r_rearm <= 1'b0;
      r_lost  <= 1'b0;
      r_ack   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rearm <= w_rearm_nxt;
      r_lost  <= w_lost_nxt;
      r_ack   <= w_ack_nxt;
      r_irq   <= (w_state_nxt == IRQ_PEND);
    end
  end

  assign o_irq     = r_irq;
  assign o_src_ack = r_ack;
  assign o_lost    = r_lost;

endmodule

// File: rtl/picodevice_irq_ctrl.sv
// Interrupt front-end for the picodevice IRQ bus: sixteen independent lines
// sharing one registered copy of the device eoi bus for edge detection.
module picodevice_irq_ctrl
  import picodevice_irq_pkg::*;
#(
  parameter int                 NUM_IRQ     = IRQ_LINES,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = 16'h0000,
  parameter int                 SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_IRQ-1:0] src_irq,
  input  logic [NUM_IRQ-1:0] enable,
  output logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] eoi,
  output logic [NUM_IRQ-1:0] src_ack,
  output logic [NUM_IRQ-1:0] lost
);

  logic [NUM_IRQ-1:0] r_eoi_d;
  logic [NUM_IRQ-1:0] w_eoi_rise;
  logic [NUM_IRQ-1:0] w_eoi_fall;

  assign w_eoi_rise = eoi & ~r_eoi_d;
  assign w_eoi_fall = ~eoi & r_eoi_d;

  // Previous eoi value; restarts at zero so eoi held across reset looks like a rise.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_eoi_d <= '0;
    end else begin
      r_eoi_d <= eoi;
    end
  end

  for (genvar g = 0; g < IRQ_LINES; g++) begin : g_line
    picodevice_irq_line #(
      .EDGE        (EDGE_MASK[g]),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_line (
      .clk        (clk),
      .resetn     (resetn),
      .i_src_irq  (src_irq[g]),
      .i_enable   (enable[g]),
      .i_eoi_rise (w_eoi_rise[g]),
      .i_eoi_fall (w_eoi_fall[g]),
      .o_irq      (irq[g]),
      .o_src_ack  (src_ack[g]),
      .o_lost     (lost[g])
    );
  end

endmodule

// File: tb/tb_picodevice_irq_ctrl.sv
// Directed bench for picodevice_irq_ctrl: line 5 edge-triggered, all others level.
module tb_picodevice_irq_ctrl;

  logic        clk;
  logic        resetn;
  logic [15:0] src_irq;
  logic [15:0] enable;
  logic [15:0] irq;
  logic [15:0] eoi;
  logic [15:0] src_ack;
  logic [15:0] lost;
  int          checks;
  int          errors;

  picodevice_irq_ctrl #(
    .NUM_IRQ     (16),
    .EDGE_MASK   (16'h0020),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .src_irq (src_irq),
    .enable  (enable),
    .irq     (irq),
    .eoi     (eoi),
    .src_ack (src_ack),
    .lost    (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse5();
    src_irq[5] = 1'b1;
    tick(3);
    src_irq[5] = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    resetn = 1'b0; src_irq = 16'h0000; enable = 16'h0000; eoi = 16'hFFFF;
    tick(2);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL reset_irq: got %h expected %h", irq, 16'h0000); end
    checks++; if (src_ack !== 16'h0000) begin errors++; $display("FAIL reset_ack: got %h expected %h", src_ack, 16'h0000); end
    checks++; if (lost !== 16'h0000) begin errors++; $display("FAIL reset_lost: got %h expected %h", lost, 16'h0000); end
    resetn = 1'b1;
    tick(3);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL eoi_held_irq: got %h expected %h", irq, 16'h0000); end
    eoi = 16'h0000;
    tick(1);
    checks++; if (src_ack !== 16'h0000) begin errors++; $display("FAIL eoi_fall_idle_ack: got %h expected %h", src_ack, 16'h0000); end
    tick(1);
  endtask

  task automatic test_level();
    enable = 16'hFFFF;
    src_irq[3] = 1'b1;
    tick(2);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL level_early: got %h expected %h", irq, 16'h0000); end
    tick(1);
    checks++; if (irq !== 16'h0008) begin errors++; $display("FAIL level_irq: got %h expected %h", irq, 16'h0008); end
    eoi[3] = 1'b1;
    tick(1);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL level_serv_irq: got %h expected %h", irq, 16'h0000); end
    src_irq[3] = 1'b0;
    tick(4);
    eoi[3] = 1'b0;
    tick(1);
    checks++; if (src_ack !== 16'h0008) begin errors++; $display("FAIL level_ack: got %h expected %h", src_ack, 16'h0008); end
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL level_ack_irq: got %h expected %h", irq, 16'h0000); end
    tick(1);
    checks++; if (src_ack !== 16'h0000) begin errors++; $display("FAIL level_ack_width: got %h expected %h", src_ack, 16'h0000); end
    tick(2);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL level_idle: got %h expected %h", irq, 16'h0000); end
  endtask

  task automatic test_edge();
    src_irq[5] = 1'b1;
    tick(3);
    checks++; if (irq !== 16'h0020) begin errors++; $display("FAIL edge_irq: got %h expected %h", irq, 16'h0020); end
    src_irq[5] = 1'b0;
    tick(3);
    eoi[5] = 1'b1;
    tick(1);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL edge_serv_irq: got %h expected %h", irq, 16'h0000); end
    pulse5();
    checks++; if (lost !== 16'h0000) begin errors++; $display("FAIL edge_rearm_lost: got %h expected %h", lost, 16'h0000); end
    eoi[5] = 1'b0;
    tick(1);
    checks++; if (src_ack !== 16'h0020) begin errors++; $display("FAIL edge_ack: got %h expected %h", src_ack, 16'h0020); end
    checks++; if (irq !== 16'h0020) begin errors++; $display("FAIL edge_rearm_irq: got %h expected %h", irq, 16'h0020); end
    tick(1);
    checks++; if (src_ack !== 16'h0000) begin errors++; $display("FAIL edge_ack_width: got %h expected %h", src_ack, 16'h0000); end
    eoi[5] = 1'b1;
    tick(1);
    pulse5();
    pulse5();
    checks++; if (lost !== 16'h0020) begin errors++; $display("FAIL edge_lost: got %h expected %h", lost, 16'h0020); end
    eoi[5] = 1'b0;
    tick(1);
    checks++; if (irq !== 16'h0020) begin errors++; $display("FAIL edge_rearm2_irq: got %h expected %h", irq, 16'h0020); end
    eoi[5] = 1'b1;
    tick(1);
    eoi[5] = 1'b0;
    tick(1);
    checks++; if (src_ack !== 16'h0020) begin errors++; $display("FAIL edge_final_ack: got %h expected %h", src_ack, 16'h0020); end
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL edge_final_irq: got %h expected %h", irq, 16'h0000); end
    tick(1);
    checks++; if (lost !== 16'h0020) begin errors++; $display("FAIL edge_lost_sticky: got %h expected %h", lost, 16'h0020); end
  endtask

  task automatic test_disable();
    src_irq[0] = 1'b1;
    tick(3);
    checks++; if (irq !== 16'h0001) begin errors++; $display("FAIL dis_pend: got %h expected %h", irq, 16'h0001); end
    enable[0] = 1'b0;
    tick(1);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL dis_drop: got %h expected %h", irq, 16'h0000); end
    src_irq[0] = 1'b0;
    tick(3);
    enable = 16'hFFFF;
    tick(3);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL dis_stay_idle: got %h expected %h", irq, 16'h0000); end
    checks++; if (src_ack !== 16'h0000) begin errors++; $display("FAIL dis_no_ack: got %h expected %h", src_ack, 16'h0000); end
  endtask

  task automatic test_level_retrigger();
    src_irq[7] = 1'b1;
    tick(3);
    checks++; if (irq !== 16'h0080) begin errors++; $display("FAIL retrig_irq: got %h expected %h", irq, 16'h0080); end
    eoi[7] = 1'b1;
    tick(1);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL retrig_serv: got %h expected %h", irq, 16'h0000); end
    eoi[7] = 1'b0;
    tick(1);
    checks++; if (src_ack !== 16'h0080) begin errors++; $display("FAIL retrig_ack: got %h expected %h", src_ack, 16'h0080); end
    checks++; if (irq !== 16'h0080) begin errors++; $display("FAIL retrig_repend: got %h expected %h", irq, 16'h0080); end
    tick(1);
    checks++; if (src_ack !== 16'h0000) begin errors++; $display("FAIL retrig_ack_width: got %h expected %h", src_ack, 16'h0000); end
    checks++; if (irq !== 16'h0080) begin errors++; $display("FAIL retrig_hold: got %h expected %h", irq, 16'h0080); end
    src_irq[7] = 1'b0;
    tick(3);
    eoi[7] = 1'b1;
    tick(1);
    eoi[7] = 1'b0;
    tick(1);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL retrig_retire: got %h expected %h", irq, 16'h0000); end
    tick(1);
  endtask

  task automatic test_concurrent();
    src_irq = src_irq | 16'h8006;
    tick(3);
    checks++; if (irq !== 16'h8006) begin errors++; $display("FAIL conc_irq: got %h expected %h", irq, 16'h8006); end
    eoi[2] = 1'b1;
    tick(1);
    checks++; if (irq !== 16'h8002) begin errors++; $display("FAIL conc_eoi2: got %h expected %h", irq, 16'h8002); end
    eoi[15] = 1'b1;
    tick(1);
    checks++; if (irq !== 16'h0002) begin errors++; $display("FAIL conc_eoi15: got %h expected %h", irq, 16'h0002); end
    src_irq = 16'h0000;
    tick(3);
    eoi[2] = 1'b0;
    tick(1);
    checks++; if (src_ack !== 16'h0004) begin errors++; $display("FAIL conc_ack2: got %h expected %h", src_ack, 16'h0004); end
    eoi[1] = 1'b1;
    tick(1);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL conc_eoi1: got %h expected %h", irq, 16'h0000); end
    eoi = 16'h0000;
    tick(1);
    checks++; if (src_ack !== 16'h8002) begin errors++; $display("FAIL conc_ack_pair: got %h expected %h", src_ack, 16'h8002); end
    tick(1);
    checks++; if (src_ack !== 16'h0000) begin errors++; $display("FAIL conc_ack_clear: got %h expected %h", src_ack, 16'h0000); end
  endtask

  task automatic test_reset_mid_serv();
    int ack_seen;
    src_irq[4] = 1'b1;
    tick(3);
    checks++; if (irq !== 16'h0010) begin errors++; $display("FAIL rst_pend: got %h expected %h", irq, 16'h0010); end
    eoi[4] = 1'b1;
    tick(1);
    src_irq[4] = 1'b0;
    tick(3);
    resetn = 1'b0;
    tick(1);
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL rst_irq: got %h expected %h", irq, 16'h0000); end
    checks++; if (src_ack !== 16'h0000) begin errors++; $display("FAIL rst_ack: got %h expected %h", src_ack, 16'h0000); end
    checks++; if (lost !== 16'h0000) begin errors++; $display("FAIL rst_lost: got %h expected %h", lost, 16'h0000); end
    resetn = 1'b1;
    tick(2);
    eoi[4] = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (src_ack !== 16'h0000) ack_seen++;
    end
    checks++; if (ack_seen != 0) begin errors++; $display("FAIL rst_no_ack: got %0d ack cycles expected 0", ack_seen); end
    checks++; if (irq !== 16'h0000) begin errors++; $display("FAIL rst_idle: got %h expected %h", irq, 16'h0000); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_level();
    test_edge();
    test_disable();
    test_level_retrigger();
    test_concurrent();
    test_reset_mid_serv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
